// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared opcode/funct codes, ALU control encodings and the DX
//            control vector for the instruction decode / hazard stage.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_DIV = 6'd26;
    localparam logic [5:0] FN_REM = 6'd27;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b100;
    localparam logic [2:0] ALU_REM = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Control bundle carried in the DX register
    typedef struct packed {
        logic       valid;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       illegal;
        logic [2:0] alu_ctr;
    } ctrl_t;

    // A bubble carries no side effects at all
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Instructions whose rt field is a source operand
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage : decode_pkg
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Purpose  : Two-read / one-write register file, write-first bypass,
//            R0 hard-wired to zero, optional reset preload.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
    parameter  int XLEN         = 32,
    parameter  int NREG         = 32,
    parameter  int INIT_PRELOAD = 1,
    localparam int RAW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [RAW-1:0]  i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [RAW-1:0]  i_raddr1,
    input  logic [RAW-1:0]  i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    logic w_wr_en;
    assign w_wr_en = i_we && (i_waddr != '0);

    // Reset contents: R1=1, R2=R3=2 when preloading, otherwise all zero
    function automatic logic [XLEN-1:0] reset_value(input int idx);
        if (INIT_PRELOAD == 0) return '0;
        if (idx == 1)          return XLEN'(1);
        if (idx == 2 || idx == 3) return XLEN'(2);
        return '0;
    endfunction

    // Next-state array: one write per cycle, never into R0
    always_comb begin
        mem_d = mem_q;
        if (w_wr_en) mem_d[i_waddr] = i_wdata;
    end

    // Storage update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= reset_value(i);
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports: R0 reads zero, a same-cycle write is seen immediately
    always_comb begin
        if (i_raddr1 == '0)                         o_rdata1 = '0;
        else if (w_wr_en && (i_waddr == i_raddr1))  o_rdata1 = i_wdata;
        else                                        o_rdata1 = mem_q[i_raddr1];

        if (i_raddr2 == '0)                         o_rdata2 = '0;
        else if (w_wr_en && (i_waddr == i_raddr2))  o_rdata2 = i_wdata;
        else                                        o_rdata2 = mem_q[i_raddr2];
    end

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/instruction_decode_hazard.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode_hazard
// Purpose  : ID stage of the 5-stage MIPS pipeline: decode, register read
//            with XM/MW forwarding, load-use stall, flush and the DX register.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decode_hazard
    import decode_pkg::*;
#(
    parameter  int XLEN         = 32,
    parameter  int NREG         = 32,
    parameter  int INIT_PRELOAD = 1,
    localparam int RAW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] PC,
    input  logic [31:0]     IR,
    input  logic            flush,
    input  logic            XM_RegWrite,
    input  logic [RAW-1:0]  XM_RD,
    input  logic [XLEN-1:0] XM_ALUout,
    input  logic            MW_RegWrite,
    input  logic            MW_MemtoReg,
    input  logic [RAW-1:0]  MW_RD,
    input  logic [XLEN-1:0] MDR,
    input  logic [XLEN-1:0] MW_ALUout,
    output logic            stall,
    output logic            valid,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            branch,
    output logic            branch_ne,
    output logic            jump,
    output logic            illegal,
    output logic [2:0]      ALUctr,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [XLEN-1:0] MD,
    output logic [15:0]     imm,
    output logic [RAW-1:0]  RD,
    output logic [XLEN-1:0] DX_PC,
    output logic [XLEN-1:0] NPC,
    output logic [XLEN-1:0] JT
);

    // Elaboration-time parameter sanity
    generate
        if (XLEN < 32) begin : g_bad_xlen
            $error("instruction_decode_hazard: XLEN must be >= 32");
        end
        if ((NREG < 2) || (NREG > 32) || ((NREG & (NREG - 1)) != 0)) begin : g_bad_nreg
            $error("instruction_decode_hazard: NREG must be a power of two in 2..32");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]      w_op;
    logic [5:0]      w_funct;
    logic [RAW-1:0]  w_rs_idx;
    logic [RAW-1:0]  w_rt_idx;
    logic [RAW-1:0]  w_rd_idx;
    logic [XLEN-1:0] w_sext_imm;
    logic [XLEN-1:0] w_jt;

    assign w_op       = IR[31:26];
    assign w_funct    = IR[5:0];
    assign w_rs_idx   = IR[21 +: RAW];
    assign w_rt_idx   = IR[16 +: RAW];
    assign w_rd_idx   = IR[11 +: RAW];
    assign w_sext_imm = {{(XLEN-16){IR[15]}}, IR[15:0]};
    assign w_jt       = {PC[XLEN-1:28], IR[25:0], 2'b00};

    // ------------------------------------------------------------------
    // Register file with write-first bypass from MW
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_mw_wdata;
    logic [XLEN-1:0] w_rf_rs;
    logic [XLEN-1:0] w_rf_rt;

    assign w_mw_wdata = MW_MemtoReg ? MDR : MW_ALUout;

    regfile_2r1w #(
        .XLEN         (XLEN),
        .NREG         (NREG),
        .INIT_PRELOAD (INIT_PRELOAD)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (MW_RegWrite),
        .i_waddr  (MW_RD),
        .i_wdata  (w_mw_wdata),
        .i_raddr1 (w_rs_idx),
        .i_raddr2 (w_rt_idx),
        .o_rdata1 (w_rf_rs),
        .o_rdata2 (w_rf_rt)
    );

    // ------------------------------------------------------------------
    // DX register state
    // ------------------------------------------------------------------
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] md_q, md_d;
    logic [15:0]     imm_q, imm_d;
    logic [RAW-1:0]  rd_q, rd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] jt_q, jt_d;

    // Operand forwarding: the younger XM result beats the MW/regfile value
    logic [XLEN-1:0] w_fwd_rs;
    logic [XLEN-1:0] w_fwd_rt;

    always_comb begin
        w_fwd_rs = w_rf_rs;
        w_fwd_rt = w_rf_rt;
        if (XM_RegWrite && (XM_RD == w_rs_idx) && (w_rs_idx != '0)) w_fwd_rs = XM_ALUout;
        if (XM_RegWrite && (XM_RD == w_rt_idx) && (w_rt_idx != '0)) w_fwd_rt = XM_ALUout;
    end

    // Load-use hazard: a load in DX feeds a source of the IF/ID instruction
    logic w_stall;
    assign w_stall = if_valid && !flush && ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) &&
                     ((rd_q == w_rs_idx) || (uses_rt(w_op) && (rd_q == w_rt_idx)));
    assign stall = w_stall;

    // Decode the IF/ID instruction into the next DX contents (bubble by default)
    always_comb begin
        ctrl_d = CTRL_BUBBLE;
        a_d    = '0;
        b_d    = '0;
        md_d   = '0;
        imm_d  = '0;
        rd_d   = '0;
        pc_d   = '0;
        jt_d   = '0;
        if (if_valid && !flush && !w_stall) begin
            ctrl_d.valid = 1'b1;
            a_d          = w_fwd_rs;
            b_d          = w_fwd_rt;
            md_d         = w_fwd_rt;
            imm_d        = IR[15:0];
            pc_d         = PC;
            jt_d         = w_jt;
            case (w_op)
                OP_RTYPE: begin
                    rd_d             = w_rd_idx;
                    ctrl_d.reg_write = 1'b1;
                    case (w_funct)
                        FN_ADD:  ctrl_d.alu_ctr = ALU_ADD;
                        FN_SUB:  ctrl_d.alu_ctr = ALU_SUB;
                        FN_AND:  ctrl_d.alu_ctr = ALU_AND;
                        FN_OR:   ctrl_d.alu_ctr = ALU_OR;
                        FN_SLT:  ctrl_d.alu_ctr = ALU_SLT;
                        FN_DIV:  ctrl_d.alu_ctr = ALU_DIV;
                        FN_REM:  ctrl_d.alu_ctr = ALU_REM;
                        default: begin
                            ctrl_d.illegal   = 1'b1;
                            ctrl_d.reg_write = 1'b0;
                        end
                    endcase
                end
                OP_LW: begin
                    b_d               = w_sext_imm;
                    rd_d              = w_rt_idx;
                    ctrl_d.mem_read   = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.alu_ctr    = ALU_ADD;
                end
                OP_SW: begin
                    b_d              = w_sext_imm;
                    rd_d             = w_rt_idx;
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.alu_ctr   = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl_d.branch  = 1'b1;
                    ctrl_d.alu_ctr = ALU_SUB;
                end
                OP_BNE: begin
                    ctrl_d.branch    = 1'b1;
                    ctrl_d.branch_ne = 1'b1;
                    ctrl_d.alu_ctr   = ALU_SUB;
                end
                OP_J: begin
                    ctrl_d.jump    = 1'b1;
                    ctrl_d.alu_ctr = ALU_AND;
                end
                default: begin
                    ctrl_d.illegal = 1'b1;
                end
            endcase
        end
    end

    // DX pipeline register; reset produces an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_BUBBLE;
            a_q    <= '0;
            b_q    <= '0;
            md_q   <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            pc_q   <= '0;
            jt_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            a_q    <= a_d;
            b_q    <= b_d;
            md_q   <= md_d;
            imm_q  <= imm_d;
            rd_q   <= rd_d;
            pc_q   <= pc_d;
            jt_q   <= jt_d;
        end
    end

    assign valid     = ctrl_q.valid;
    assign MemtoReg  = ctrl_q.mem_to_reg;
    assign RegWrite  = ctrl_q.reg_write;
    assign MemRead   = ctrl_q.mem_read;
    assign MemWrite  = ctrl_q.mem_write;
    assign branch    = ctrl_q.branch;
    assign branch_ne = ctrl_q.branch_ne;
    assign jump      = ctrl_q.jump;
    assign illegal   = ctrl_q.illegal;
    assign ALUctr    = ctrl_q.alu_ctr;
    assign A         = a_q;
    assign B         = b_q;
    assign MD        = md_q;
    assign imm       = imm_q;
    assign RD        = rd_q;
    assign DX_PC     = pc_q;
    assign NPC       = pc_q;
    assign JT        = jt_q;

endmodule : instruction_decode_hazard
`default_nettype wire

// File: tb/tb_instruction_decode_hazard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode_hazard
// Purpose  : Scoreboard bench: directed scenarios plus random traffic against
//            a behavioural ID-stage model; second instance at XLEN=64/NREG=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decode_hazard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- main instance (XLEN=32, NREG=32) ----------------
    logic        rst = 1'b1, if_valid = 1'b0, flush = 1'b0;
    logic [31:0] PC = '0, IR = '0;
    logic        XM_RegWrite = 1'b0, MW_RegWrite = 1'b0, MW_MemtoReg = 1'b0;
    logic [4:0]  XM_RD = '0, MW_RD = '0;
    logic [31:0] XM_ALUout = '0, MDR = '0, MW_ALUout = '0;
    logic        stall, valid, MemtoReg, RegWrite, MemRead, MemWrite, branch, branch_ne, jump, illegal;
    logic [2:0]  ALUctr;
    logic [31:0] A, B, MD, DX_PC, NPC, JT;
    logic [15:0] imm;
    logic [4:0]  RD;

    instruction_decode_hazard #(.XLEN(32), .NREG(32), .INIT_PRELOAD(1)) u_dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .PC(PC), .IR(IR), .flush(flush),
        .XM_RegWrite(XM_RegWrite), .XM_RD(XM_RD), .XM_ALUout(XM_ALUout),
        .MW_RegWrite(MW_RegWrite), .MW_MemtoReg(MW_MemtoReg), .MW_RD(MW_RD),
        .MDR(MDR), .MW_ALUout(MW_ALUout),
        .stall(stall), .valid(valid), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .branch(branch), .branch_ne(branch_ne),
        .jump(jump), .illegal(illegal), .ALUctr(ALUctr), .A(A), .B(B), .MD(MD),
        .imm(imm), .RD(RD), .DX_PC(DX_PC), .NPC(NPC), .JT(JT)
    );

    // ---------------- wide instance (XLEN=64, NREG=16) ----------------
    logic        rst_w = 1'b1, if_valid_w = 1'b0, flush_w = 1'b0;
    logic [63:0] PC_w = '0;
    logic [31:0] IR_w = '0;
    logic        xw_w = 1'b0, mw_w = 1'b0, m2r_w = 1'b0;
    logic [3:0]  xrd_w = '0, mrd_w = '0;
    logic [63:0] xo_w = '0, mdr_w = '0, malu_w = '0;
    logic        stall_w, valid_w, m2r_o_w, rw_o_w, mr_o_w, mwr_o_w, br_o_w, bne_o_w, j_o_w, ill_o_w;
    logic [2:0]  alu_o_w;
    logic [63:0] A_w, B_w, MD_w, DX_PC_w, NPC_w, JT_w;
    logic [15:0] imm_o_w;
    logic [3:0]  RD_w;

    instruction_decode_hazard #(.XLEN(64), .NREG(16), .INIT_PRELOAD(1)) u_dut_w (
        .clk(clk), .rst(rst_w), .if_valid(if_valid_w), .PC(PC_w), .IR(IR_w), .flush(flush_w),
        .XM_RegWrite(xw_w), .XM_RD(xrd_w), .XM_ALUout(xo_w),
        .MW_RegWrite(mw_w), .MW_MemtoReg(m2r_w), .MW_RD(mrd_w),
        .MDR(mdr_w), .MW_ALUout(malu_w),
        .stall(stall_w), .valid(valid_w), .MemtoReg(m2r_o_w), .RegWrite(rw_o_w),
        .MemRead(mr_o_w), .MemWrite(mwr_o_w), .branch(br_o_w), .branch_ne(bne_o_w),
        .jump(j_o_w), .illegal(ill_o_w), .ALUctr(alu_o_w), .A(A_w), .B(B_w), .MD(MD_w),
        .imm(imm_o_w), .RD(RD_w), .DX_PC(DX_PC_w), .NPC(NPC_w), .JT(JT_w)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid, m2r, rw, mr, mw, br, bne, jmp, ill;
        logic [2:0]  alu;
        logic [31:0] a, b, md;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc, npc, jt;
    } dx_t;

    dx_t         exp_q[$];
    dx_t         prev_dx = '0;
    logic [31:0] rf_m [32];
    logic [2:0]  alu_of [logic [5:0]];
    logic        last_stall = 1'b0;

    // side-band write-back / forwarding inputs used by the next step
    logic        s_xw = 0, s_mw = 0, s_m2r = 0;
    logic [4:0]  s_xrd = 0, s_mrd = 0;
    logic [31:0] s_xo = 0, s_mdr = 0, s_malu = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void rf_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'(0);
        rf_m[1] = 32'd1;
        rf_m[2] = 32'd2;
        rf_m[3] = 32'd2;
    endfunction

    // value of register idx as seen by decode this cycle
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] wdat);
        if (idx == 5'd0)                  return 32'd0;
        if (s_xw && s_xrd == idx)         return s_xo;
        if (s_mw && s_mrd == idx)         return wdat;
        return rf_m[idx];
    endfunction

    function automatic dx_t model_decode(input logic [31:0] ir, input logic [31:0] pc,
                                         input logic [31:0] va, input logic [31:0] vb);
        dx_t         e = '0;
        logic [31:0] sx = {{16{ir[15]}}, ir[15:0]};
        logic [5:0]  op = ir[31:26];
        e.valid = 1; e.a = va; e.b = vb; e.md = vb; e.imm = ir[15:0];
        e.pc = pc; e.npc = pc; e.jt = {pc[31:28], ir[25:0], 2'b00};
        if (op == 6'd0) begin
            e.rd = ir[15:11];
            if (alu_of.exists(ir[5:0])) begin e.rw = 1; e.alu = alu_of[ir[5:0]]; end
            else e.ill = 1;
        end else if (op == 6'd35) begin
            e.b = sx; e.rd = ir[20:16]; e.mr = 1; e.m2r = 1; e.rw = 1; e.alu = 3'b010;
        end else if (op == 6'd43) begin
            e.b = sx; e.rd = ir[20:16]; e.mw = 1; e.alu = 3'b010;
        end else if (op == 6'd4 || op == 6'd5) begin
            e.br = 1; e.bne = (op == 6'd5); e.alu = 3'b110;
        end else if (op == 6'd2) begin
            e.jmp = 1;
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    // One clock of stimulus: drive, check combinational stall, queue DX result
    task automatic step(input logic t_rst, input logic t_iv, input logic t_fl,
                        input logic [31:0] t_ir, input logic [31:0] t_pc, output logic s_obs);
        logic [31:0] wdat;
        logic [4:0]  rs, rt;
        logic [5:0]  op;
        logic        src_rt, s_exp;
        dx_t         nxt;
        @(negedge clk);
        rst = t_rst; if_valid = t_iv; flush = t_fl; IR = t_ir; PC = t_pc;
        XM_RegWrite = s_xw; XM_RD = s_xrd; XM_ALUout = s_xo;
        MW_RegWrite = s_mw; MW_MemtoReg = s_m2r; MW_RD = s_mrd; MDR = s_mdr; MW_ALUout = s_malu;
        wdat   = s_m2r ? s_mdr : s_malu;
        rs     = t_ir[25:21];
        rt     = t_ir[20:16];
        op     = t_ir[31:26];
        src_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
        s_exp  = t_iv && !t_fl && prev_dx.valid && prev_dx.mr && (prev_dx.rd != 0) &&
                 (prev_dx.rd == rs || (src_rt && prev_dx.rd == rt));
        #1;
        chk("stall", 64'(stall), 64'(s_exp));
        s_obs = stall;
        if (t_rst || t_fl || !t_iv || s_exp) nxt = '0;
        else nxt = model_decode(t_ir, t_pc, operand(rs, wdat), operand(rt, wdat));
        exp_q.push_back(nxt);
        prev_dx    = nxt;
        last_stall = s_exp;
        if (t_rst) rf_reset();
        else if (s_mw && s_mrd != 0) rf_m[s_mrd] = wdat;
    endtask

    // Monitor: compare DX contents after every edge against the scoreboard
    always @(posedge clk) begin
        dx_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{valid, MemtoReg, RegWrite, MemRead, MemWrite, branch, branch_ne, jump, illegal,
                  ALUctr, A, B, MD, imm, RD, DX_PC, NPC, JT};
            n_checks++;
            if (a !== e) begin
                n_err++;
                $display("FAIL dx actual=%h required=%h", a, e);
            end
        end
    end

    function automatic logic [31:0] rand_ir();
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] fl [8];
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd26, 6'd27, 6'd0};
        case ($urandom_range(0, 9))
            0, 1:    op = 6'd0;
            2, 7:    op = 6'd35;
            3:       op = 6'd43;
            4:       op = 6'd4;
            5:       op = 6'd5;
            6:       op = 6'd2;
            default: op = 6'($urandom);
        endcase
        fn = fl[$urandom_range(0, 7)];
        if (fn == 6'd0) fn = 6'($urandom);
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom), fn};
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic        r_iv;
        logic [31:0] r_ir, r_pc;
        alu_of[6'd32] = 3'b010; alu_of[6'd34] = 3'b110; alu_of[6'd36] = 3'b000;
        alu_of[6'd37] = 3'b001; alu_of[6'd42] = 3'b111; alu_of[6'd26] = 3'b100;
        alu_of[6'd27] = 3'b101;
        rf_reset();

        // reset held from time zero; DX must be empty afterwards
        @(posedge clk); #2;
        chk("reset_dx", 64'({valid, RegWrite, MemRead, MemWrite, branch, jump, illegal, ALUctr, RD}), 64'd0);
        chk("reset_A", 64'(A), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);

        step(1, 0, 0, 32'h0, 32'h0, s);
        // add r4,r1,r2
        step(0, 1, 0, {6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'd32}, 32'h100, s);
        @(posedge clk); #2;
        chk("add_A", 64'(A), 64'd1);
        chk("add_B", 64'(B), 64'd2);
        chk("add_ctl", 64'({valid, RegWrite, ALUctr, RD}), 64'({1'b1, 1'b1, 3'b010, 5'd4}));
        // lw r5,8(r1) then sub r6,r5,r2 -> one stall cycle
        step(0, 1, 0, {6'd35, 5'd1, 5'd5, 16'd8}, 32'h104, s);
        step(0, 1, 0, {6'd0, 5'd5, 5'd2, 5'd6, 5'd0, 6'd34}, 32'h108, s);
        chk("lu_stall", 64'(s), 64'd1);
        @(posedge clk); #2;
        chk("lu_bubble", 64'({valid, RegWrite}), 64'd0);
        s_xw = 1; s_xrd = 5'd5; s_xo = 32'h99;
        step(0, 1, 0, {6'd0, 5'd5, 5'd2, 5'd6, 5'd0, 6'd34}, 32'h108, s);
        chk("lu_release", 64'(s), 64'd0);
        @(posedge clk); #2;
        chk("fwd_xm_A", 64'(A), 64'h99);
        chk("sub_alu", 64'(ALUctr), 64'b110);
        s_xw = 0; s_xrd = 0; s_xo = 0;
        // or r8,r7,r0 with MW writing MDR into r7
        s_mw = 1; s_m2r = 1; s_mrd = 5'd7; s_mdr = 32'hDEAD;
        step(0, 1, 0, {6'd0, 5'd7, 5'd0, 5'd8, 5'd0, 6'd37}, 32'h10C, s);
        @(posedge clk); #2;
        chk("bypass_A", 64'(A), 64'hDEAD);
        chk("bypass_B", 64'(B), 64'd0);
        // write 0x55 to r0, then read r0
        s_m2r = 0; s_mrd = 5'd0; s_malu = 32'h55;
        step(0, 1, 0, {6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'd37}, 32'h110, s);
        s_mw = 0; s_malu = 0; s_mdr = 0;
        step(0, 1, 0, {6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'd32}, 32'h114, s);
        @(posedge clk); #2;
        chk("r0_read", 64'({A, B}), 64'd0);
        // sw r2,-4(r3)
        step(0, 1, 0, {6'd43, 5'd3, 5'd2, 16'hFFFC}, 32'h118, s);
        @(posedge clk); #2;
        chk("sw_B", 64'(B), 64'hFFFFFFFC);
        chk("sw_MD", 64'(MD), 64'd2);
        chk("sw_ctl", 64'({MemWrite, RegWrite}), 64'b10);
        // j 0x10 at PC 0x40000000, then with flush
        step(0, 1, 0, {6'd2, 26'h10}, 32'h40000000, s);
        @(posedge clk); #2;
        chk("j_JT", 64'(JT), 64'h40000040);
        chk("j_jump", 64'(jump), 64'd1);
        step(0, 1, 1, {6'd2, 26'h10}, 32'h40000000, s);
        @(posedge clk); #2;
        chk("flush", 64'({valid, jump}), 64'd0);
        // undefined opcode
        step(0, 1, 0, {6'd63, 26'h0}, 32'h200, s);
        @(posedge clk); #2;
        chk("illegal", 64'({illegal, RegWrite, MemWrite, valid}), 64'b1001);
        // reset while a load-use stall is pending
        step(0, 1, 0, {6'd35, 5'd1, 5'd5, 16'd8}, 32'h300, s);
        step(1, 1, 0, {6'd0, 5'd5, 5'd2, 5'd6, 5'd0, 6'd34}, 32'h304, s);
        chk("rst_stall_pre", 64'(s), 64'd1);
        step(0, 1, 0, {6'd0, 5'd5, 5'd2, 5'd6, 5'd0, 6'd34}, 32'h304, s);
        chk("rst_stall_clr", 64'(s), 64'd0);

        // random traffic; IF/ID holds its contents while stalled
        r_iv = 1; r_ir = 0; r_pc = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!last_stall) begin
                r_iv = ($urandom_range(0, 7) != 0);
                r_ir = rand_ir();
                r_pc = $urandom;
            end
            s_xw = 1'($urandom); s_xrd = 5'($urandom_range(0, 7)); s_xo = $urandom;
            s_mw = 1'($urandom); s_m2r = 1'($urandom); s_mrd = 5'($urandom_range(0, 7));
            s_mdr = $urandom; s_malu = $urandom;
            step(($urandom_range(0, 99) == 0), r_iv, ($urandom_range(0, 7) == 0), r_ir, r_pc, s);
        end
        @(posedge clk); #3;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // ---------------- wide instance ----------------
        chk("w_reset", 64'({valid_w, stall_w, RD_w}), 64'd0);
        @(negedge clk); rst_w = 0; if_valid_w = 1; IR_w = {6'd4, 5'd1, 5'd2, 16'd0}; PC_w = 64'h1000;
        @(posedge clk); #2;
        chk("w_beq_ctl", 64'({valid_w, br_o_w, bne_o_w, alu_o_w}), 64'({3'b110, 3'b110}));
        chk("w_beq_A", A_w, 64'd1);
        chk("w_beq_B", B_w, 64'd2);
        @(negedge clk); IR_w = {6'd4, 5'd17, 5'd18, 16'd0};
        @(posedge clk); #2;
        chk("w_trunc", {A_w[31:0], B_w[31:0]}, {32'd1, 32'd2});
        @(negedge clk); IR_w = {6'd35, 5'd1, 5'd3, 16'hFFFC};
        @(posedge clk); #2;
        chk("w_lw_B", B_w, 64'hFFFFFFFFFFFFFFFC);
        chk("w_lw_ctl", 64'({mr_o_w, RD_w}), 64'({1'b1, 4'd3}));
        @(negedge clk); IR_w = {6'd0, 5'd3, 5'd2, 5'd6, 5'd0, 6'd34}; #1;
        chk("w_stall", 64'(stall_w), 64'd1);
        @(posedge clk); #2;
        chk("w_bubble", 64'(valid_w), 64'd0);
        @(negedge clk); IR_w = {6'd2, 26'h10}; PC_w = 64'h40000000;
        @(posedge clk); #2;
        chk("w_JT", JT_w, 64'h40000040);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule : tb_instruction_decode_hazard
`default_nettype wire
